// File: rtl/fix_msg_reader.sv
// Streams one stored FIX message from start to end address (inclusive, wrapping)
// through a 2-entry output buffer, then pulses release_o with the freed end address.
module fix_msg_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  desc_valid_i,
    output logic                  desc_ready_o,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  logic [ADDR_WIDTH-1:0] end_addr_i,
    output logic                  mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  sop_o,
    output logic                  eop_o,
    output logic                  release_o,
    output logic [ADDR_WIDTH-1:0] release_addr_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   rd_addr_reg;
    logic [ADDR_WIDTH-1:0]   end_addr_reg;
    logic [ADDR_WIDTH:0]     remaining_reg;
    logic                    first_reg;
    logic                    inflight_reg;
    logic                    inflight_sop_reg;
    logic                    inflight_eop_reg;
    logic                    release_reg;
    logic [ADDR_WIDTH-1:0]   release_addr_reg;

    // Entry layout: {sop, eop, data}
    logic [DATA_WIDTH+1:0]   fifo_mem [2];
    logic                    wr_ptr_reg;
    logic                    rd_ptr_reg;
    logic [1:0]              count_reg;

    logic                    push;
    logic                    pop;
    logic                    issue;
    logic [2:0]              occ_next;
    logic [ADDR_WIDTH-1:0]   span;
    logic [DATA_WIDTH+1:0]   head;

    assign head     = fifo_mem[rd_ptr_reg];
    assign valid_o  = (count_reg != 2'd0);
    assign pop      = valid_o && ready_i;
    assign push     = inflight_reg;
    assign span     = end_addr_i - start_addr_i;

    // Words buffered plus words still in the RAM pipeline, after this cycle's pop.
    assign occ_next = 3'(count_reg) + 3'(inflight_reg) - 3'(pop);
    assign issue    = (state_reg == READ) && (occ_next < 3'd2);

    assign mem_rd_en_o    = issue;
    assign mem_rd_addr_o  = rd_addr_reg;
    assign data_o         = valid_o ? head[DATA_WIDTH-1:0] : '0;
    assign sop_o          = valid_o && head[DATA_WIDTH+1];
    assign eop_o          = valid_o && head[DATA_WIDTH];
    assign desc_ready_o   = (state_reg == IDLE);
    assign busy_o         = (state_reg != IDLE);
    assign release_o      = release_reg;
    assign release_addr_o = release_addr_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {inflight_sop_reg, inflight_eop_reg, mem_rd_data_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            rd_addr_reg      <= '0;
            end_addr_reg     <= '0;
            remaining_reg    <= '0;
            first_reg        <= 1'b0;
            inflight_reg     <= 1'b0;
            inflight_sop_reg <= 1'b0;
            inflight_eop_reg <= 1'b0;
            release_reg      <= 1'b0;
            release_addr_reg <= '0;
            wr_ptr_reg       <= 1'b0;
            rd_ptr_reg       <= 1'b0;
            count_reg        <= 2'd0;
        end else begin
            release_reg      <= 1'b0;
            inflight_reg     <= issue;
            inflight_sop_reg <= first_reg;
            inflight_eop_reg <= (remaining_reg == (ADDR_WIDTH+1)'(1));

            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + 2'(push) - 2'(pop);

            case (state_reg)
                IDLE: begin
                    if (desc_valid_i) begin
                        rd_addr_reg   <= start_addr_i;
                        end_addr_reg  <= end_addr_i;
                        // end == start-1 yields a full-depth message
                        remaining_reg <= {1'b0, span} + (ADDR_WIDTH+1)'(1);
                        first_reg     <= 1'b1;
                        state_reg     <= READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        rd_addr_reg   <= rd_addr_reg + ADDR_WIDTH'(1);
                        remaining_reg <= remaining_reg - (ADDR_WIDTH+1)'(1);
                        first_reg     <= 1'b0;
                        if (remaining_reg == (ADDR_WIDTH+1)'(1)) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && head[DATA_WIDTH]) begin
                        release_reg      <= 1'b1;
                        release_addr_reg <= end_addr_reg;
                        state_reg        <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fix_msg_reader.sv
// Randomized scoreboard bench for fix_msg_reader: expected reads, words and
// releases are queued by the driver and consumed by an independent monitor.
module tb_fix_msg_reader;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          desc_valid_i;
    logic          desc_ready_o;
    logic [AW-1:0] start_addr_i;
    logic [AW-1:0] end_addr_i;
    logic          mem_rd_en_o;
    logic [AW-1:0] mem_rd_addr_o;
    logic [DW-1:0] mem_rd_data_i;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;
    logic          sop_o;
    logic          eop_o;
    logic          release_o;
    logic [AW-1:0] release_addr_o;
    logic          busy_o;

    always #5 clk = ~clk;

    fix_msg_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
        .start_addr_i(start_addr_i), .end_addr_i(end_addr_i),
        .mem_rd_en_o(mem_rd_en_o), .mem_rd_addr_o(mem_rd_addr_o),
        .mem_rd_data_i(mem_rd_data_i),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .sop_o(sop_o), .eop_o(eop_o),
        .release_o(release_o), .release_addr_o(release_addr_o),
        .busy_o(busy_o)
    );

    // Storage model: one-cycle read latency, garbage when not read.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) mem_rd_data_i <= mem_rd_en_o ? mem[mem_rd_addr_o] : DW'($urandom);

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } word_t;

    word_t         word_q [$];
    logic [AW-1:0] addr_q [$];
    logic [AW-1:0] rel_q  [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sop_cyc_exp = 0;
    bit sop_wait = 0;
    int nb_lo = 0;
    int nb_hi = -1;
    int rel_cyc_exp = -1;
    int reads = 0;
    int pops = 0;
    bit prev_stall = 0;
    logic [DW+1:0] prev_out;
    word_t mon_w;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: samples mid-cycle, consumes the scoreboard queues.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(valid_o), 64'd1);
                chk("stall_data", 64'({sop_o, eop_o, data_o}), 64'(prev_out));
            end
            if (cyc >= nb_lo && cyc <= nb_hi) chk("no_bubble", 64'(valid_o), 64'd1);
            if (mem_rd_en_o) begin
                chk("credit", 64'((reads - pops - int'(valid_o && ready_i)) < 2), 64'd1);
                if (addr_q.size() == 0) chk("unexpected_read", 64'(mem_rd_addr_o), 64'hffff);
                else chk("rd_addr", 64'(mem_rd_addr_o), 64'(addr_q.pop_front()));
                reads++;
            end
            if (valid_o && sop_o && sop_wait) begin
                chk("sop_latency", 64'(cyc), 64'(sop_cyc_exp));
                sop_wait = 0;
            end
            if (valid_o && ready_i) begin
                if (word_q.size() == 0) begin
                    chk("unexpected_word", 64'(data_o), 64'hffff_ffff_ffff);
                end else begin
                    mon_w = word_q.pop_front();
                    chk("word_data", 64'(data_o), 64'(mon_w.data));
                    chk("word_sop", 64'(sop_o), 64'(mon_w.sop));
                    chk("word_eop", 64'(eop_o), 64'(mon_w.eop));
                    if (mon_w.eop) rel_cyc_exp = cyc + 1;
                end
                pops++;
            end
            if (release_o) begin
                if (rel_q.size() == 0) begin
                    chk("spurious_release", 64'(release_o), 64'd0);
                end else begin
                    chk("release_addr", 64'(release_addr_o), 64'(rel_q.pop_front()));
                    chk("release_cycle", 64'(cyc), 64'(rel_cyc_exp));
                    chk("release_busy", 64'(busy_o), 64'd0);
                    chk("release_desc_ready", 64'(desc_ready_o), 64'd1);
                end
            end
            prev_stall = valid_o && !ready_i;
            prev_out   = {sop_o, eop_o, data_o};
        end
    end

    task automatic flush_model();
        word_q.delete();
        addr_q.delete();
        rel_q.delete();
        reads = 0;
        pops = 0;
        sop_wait = 0;
        nb_hi = -1;
        rel_cyc_exp = -1;
    endtask

    task automatic load_expect(input logic [AW-1:0] s, input logic [AW-1:0] e, output int len);
        int a;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        // Walk from start until end is reached: message length by definition.
        len = 1;
        a = int'(s);
        while (a != int'(e)) begin
            a = (a + 1) % DEPTH;
            len++;
        end
        for (int i = 0; i < len; i++) begin
            a = (int'(s) + i) % DEPTH;
            addr_q.push_back(AW'(a));
            word_q.push_back('{data: mem[a], sop: (i == 0), eop: (i == len - 1)});
        end
        rel_q.push_back(e);
    endtask

    task automatic send_desc(input logic [AW-1:0] s, input logic [AW-1:0] e, input bit rnd, input int len);
        bit got;
        got = 0;
        @(posedge clk); #1;
        start_addr_i = s;
        end_addr_i   = e;
        desc_valid_i = 1'b1;
        ready_i      = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (desc_ready_o) got = 1;
            else begin @(posedge clk); #1; end
        end
        chk("desc_accept", 64'(got), 64'd1);
        sop_cyc_exp = cyc + 3;
        sop_wait = 1;
        if (!rnd) begin
            nb_lo = cyc + 3;
            nb_hi = cyc + 2 + len;
        end
    endtask

    task automatic run_msg(input logic [AW-1:0] s, input logic [AW-1:0] e, input bit rnd);
        int len;
        bit done;
        load_expect(s, e, len);
        send_desc(s, e, rnd, len);
        done = 0;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(posedge clk); #1;
            desc_valid_i = 1'b0;
            start_addr_i = AW'($urandom);
            end_addr_i   = AW'($urandom);
            ready_i      = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rel_q.size() == 0) done = 1;
        end
        chk("msg_complete", 64'(done), 64'd1);
        chk("words_left", 64'(word_q.size()), 64'd0);
        chk("reads_left", 64'(addr_q.size()), 64'd0);
        $display("msg start=%0d end=%0d len=%0d rnd=%0b checks=%0d errors=%0d", s, e, len, rnd, checks, errors);
        flush_model();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0] s;
        logic [AW-1:0] e;
        int len;
        rst = 1'b1;
        desc_valid_i = 1'b0;
        ready_i = 1'b0;
        start_addr_i = '0;
        end_addr_i = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_desc_ready", 64'(desc_ready_o), 64'd1);
        chk("reset_rd_en", 64'(mem_rd_en_o), 64'd0);
        chk("reset_rd_addr", 64'(mem_rd_addr_o), 64'd0);
        chk("reset_data", 64'(data_o), 64'd0);
        chk("reset_valid", 64'(valid_o), 64'd0);
        chk("reset_sop_eop", 64'({sop_o, eop_o}), 64'd0);
        chk("reset_release", 64'({release_o, release_addr_o}), 64'd0);
        chk("reset_busy", 64'(busy_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ready_i = 1'b1;

        run_msg(5'd7, 5'd7, 1'b0);
        run_msg(5'd2, 5'd5, 1'b0);
        run_msg(5'd30, 5'd1, 1'b0);
        run_msg(5'd10, 5'd9, 1'b0);
        for (int i = 0; i < 4; i++) begin
            s = AW'($urandom);
            run_msg(s, s + AW'(7), 1'b1);
        end
        for (int i = 0; i < 10; i++) begin
            run_msg(AW'($urandom), AW'($urandom), 1'($urandom_range(0, 1)));
        end

        // Reset with a read in flight, then a fresh message.
        load_expect(5'd12, 5'd19, len);
        send_desc(5'd12, 5'd19, 1'b0, len);
        @(posedge clk); #1;
        desc_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        ready_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        flush_model();
        @(negedge clk);
        chk("post_rst_valid", 64'(valid_o), 64'd0);
        chk("post_rst_busy", 64'(busy_o), 64'd0);
        chk("post_rst_desc_ready", 64'(desc_ready_o), 64'd1);
        chk("post_rst_release", 64'(release_o), 64'd0);
        $display("reset mid-message checks=%0d errors=%0d", checks, errors);
        repeat (3) @(posedge clk);
        e = AW'($urandom);
        run_msg(e, e + AW'(5), 1'b1);
        run_msg(5'd0, 5'd31, 1'b1);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fix_msg_reader.md
# fix_msg_reader

Reads a complete FIX message back out of the tag CAM's storage array, from a stored start address to a stored end address, and streams it as words with start/end-of-message markers under a valid/ready handshake. It is the read side of the CAM write controller: that controller records each message's start/end addresses and advances the write pointer; this block consumes those address pairs, fetches the words and reports the freed region back so the writer can clear its full condition.

## Interface
- DATA_WIDTH, 32, stored word width
- ADDR_WIDTH, 5, storage address width; depth = 2^ADDR_WIDTH
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- desc_valid_i  input  1  message descriptor valid
- desc_ready_o  output  1  descriptor accepted when valid && ready
- start_addr_i  input  ADDR_WIDTH  address of first word
- end_addr_i  input  ADDR_WIDTH  address of last word (inclusive)
- mem_rd_en_o  output  1  storage read strobe
- mem_rd_addr_o  output  ADDR_WIDTH  storage read address
- mem_rd_data_i  input  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en_o
- data_o  output  DATA_WIDTH  message word
- valid_o  output  1  data_o valid
- ready_i  input  1  downstream accepts word when valid_o && ready_i
- sop_o  output  1  data_o is first word of message
- eop_o  output  1  data_o is last word of message
- release_o  output  1  one-cycle pulse: message fully delivered
- release_addr_o  output  ADDR_WIDTH  end address of released message, valid with release_o
- busy_o  output  1  message in progress (state != IDLE)

## Operation
- FSM states IDLE, READ, DRAIN.
- IDLE: desc_ready_o=1. On desc_valid_i && desc_ready_o: latch start/end, rd_addr <= start, remaining <= ((end - start) mod 2^ADDR_WIDTH) + 1, go READ.
- Length arithmetic: ADDR_WIDTH+1-bit remaining counter; start==end gives 1 word; end == start-1 (mod depth) gives 2^ADDR_WIDTH words.
- READ: issue read (mem_rd_en_o=1, mem_rd_addr_o=rd_addr) when credit allows; rd_addr increments mod 2^ADDR_WIDTH (31 -> 0 wraps with no gap), remaining decrements. Issuing the last word -> DRAIN.
- Output buffer: 2-entry FIFO fed by returned read data. Credit rule: issue only if (fifo_count + inflight - pop) < 2, pop = valid_o && ready_i. Returned data never dropped, no overflow under any ready_i pattern.
- valid_o = FIFO non-empty; data_o = FIFO head; data_o/sop_o/eop_o held stable while valid_o && !ready_i.
- sop_o tags the first word read for the message, eop_o the last; single-word message has both set.
- DRAIN: no reads. On handshake of eop word: release_o pulse, release_addr_o = latched end, go IDLE.
- Descriptor not accepted outside IDLE; desc_valid_i ignored when desc_ready_o=0.
- Reset (any state, any cycle): state IDLE, FIFO flushed, inflight cleared, read data returning the cycle after reset discarded.
- Reset values: desc_ready_o=1, mem_rd_en_o=0, mem_rd_addr_o=0, data_o=0, valid_o=0, sop_o=0, eop_o=0, release_o=0, release_addr_o=0, busy_o=0.

## Timing
- Descriptor handshake in cycle N; first mem_rd_en_o in N+1; data on mem_rd_data_i in N+2; valid_o && sop_o in N+3.
- With ready_i held high: one word per cycle, no bubbles, including across address wrap.
- Last word handshake in cycle M: release_o=1 and busy_o=0, desc_ready_o=1 in M+1; next descriptor earliest accepted in M+1.
- ready_i low: at most 2 words buffered, reads stall; on ready_i rising, output resumes next cycle with no lost or duplicated word.
- All outputs registered or decoded from registered state; no combinational path from ready_i to mem_rd_en_o other than through the pop term of the credit rule.

## Test plan
- Single word, start=7 end=7, ready_i=1 -> one read at addr 7; one word with sop_o=1 eop_o=1 at N+3; release_o with release_addr_o=7 next cycle.
- 4 words, start=2 end=5, ready_i=1 -> reads 2,3,4,5 consecutive cycles; 4 consecutive valid_o words, sop on first, eop on fourth.
- Wrap, ADDR_WIDTH=5, start=30 end=1 -> reads 30,31,0,1; 4 words out in order.
- Full depth, start=10 end=9 -> 32 reads, 32 words, eop on word from addr 9.
- Backpressure, 8-word message, ready_i random 50% -> output sequence exactly matches memory content, data_o stable while stalled, FIFO never exceeds 2.
- Reset asserted mid-message with one read in flight -> next cycle valid_o=0, busy_o=0, desc_ready_o=1, no release_o; new descriptor then read correctly from its sop.
